// File: rtl/usb_rx_packet_ctrl.sv
// USB full-speed receive packet sequencer: frames SYNC..EOP, assembles LSB-first bytes,
// checks the PID and reports clean end or a classified error. Optional PID check: USB_RX_PID_CHECK_EN.
module usb_rx_packet_ctrl #(
  parameter int MAX_BYTES = 1026,
  parameter int CNT_W     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             sync_detected,
  input  logic             eop,
  input  logic             stuff_err,
  output logic             rx_active,
  output logic [3:0]       pid,
  output logic             pid_valid,
  output logic [7:0]       rx_data,
  output logic             rx_data_valid,
  output logic [CNT_W-1:0] rx_byte_cnt,
  output logic             rx_packet_end,
  output logic             rx_error,
  output logic [2:0]       rx_err_code
);

  typedef enum logic [1:0] {S_IDLE, S_PID, S_DATA, S_ERR_WAIT} state_t;

  localparam logic [2:0] ERR_PID   = 3'd1;
  localparam logic [2:0] ERR_STUFF = 3'd2;
  localparam logic [2:0] ERR_ALIGN = 3'd3;
  localparam logic [2:0] ERR_OVF   = 3'd4;

  // Once this many data bytes are delivered, PID + data already fills MAX_BYTES.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BYTES - 1);

  state_t           state, state_nx;
  logic [7:0]       shreg, shreg_nx;
  logic [2:0]       bit_cnt, bit_cnt_nx;
  logic [3:0]       pid_nx;
  logic             pid_valid_nx;
  logic [7:0]       rx_data_nx;
  logic             rx_data_valid_nx;
  logic [CNT_W-1:0] rx_byte_cnt_nx;
  logic             rx_packet_end_nx;
  logic             rx_error_nx;
  logic [2:0]       rx_err_code_nx;
  logic [7:0]       byte_full;
  logic             last_bit;
  logic             pid_ok;

  assign byte_full = {bit_in, shreg[7:1]};
  assign last_bit  = (bit_cnt == 3'd7);

`ifdef USB_RX_PID_CHECK_EN
  assign pid_ok = (byte_full[7:4] == ~byte_full[3:0]);
`else
  assign pid_ok = 1'b1;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_nx         = state;
    shreg_nx         = shreg;
    bit_cnt_nx       = bit_cnt;
    pid_nx           = pid;
    pid_valid_nx     = 1'b0;
    rx_data_nx       = rx_data;
    rx_data_valid_nx = 1'b0;
    rx_byte_cnt_nx   = rx_byte_cnt;
    rx_packet_end_nx = 1'b0;
    rx_error_nx      = 1'b0;
    rx_err_code_nx   = rx_err_code;

    case (state)
      S_IDLE, S_ERR_WAIT: begin
        if (sync_detected) begin
          state_nx       = S_PID;
          shreg_nx       = 8'h00;
          bit_cnt_nx     = 3'd0;
          rx_byte_cnt_nx = '0;
        end else if (eop) begin
          state_nx = S_IDLE;
        end
      end
      S_PID: begin
        if (stuff_err) begin
          rx_error_nx    = 1'b1;
          rx_err_code_nx = ERR_STUFF;
          state_nx       = S_ERR_WAIT;
        end else if (eop) begin
          rx_error_nx    = 1'b1;
          rx_err_code_nx = ERR_ALIGN;
          state_nx       = S_IDLE;
        end else if (bit_valid) begin
          shreg_nx   = byte_full;
          bit_cnt_nx = bit_cnt + 3'd1;
          if (last_bit) begin
            if (pid_ok) begin
              pid_nx       = byte_full[3:0];
              pid_valid_nx = 1'b1;
              state_nx     = S_DATA;
            end else begin
              rx_error_nx    = 1'b1;
              rx_err_code_nx = ERR_PID;
              state_nx       = S_ERR_WAIT;
            end
          end
        end
      end
      S_DATA: begin
        if (stuff_err) begin
          rx_error_nx    = 1'b1;
          rx_err_code_nx = ERR_STUFF;
          state_nx       = S_ERR_WAIT;
        end else if (eop) begin
          state_nx = S_IDLE;
          if (bit_cnt == 3'd0) begin
            rx_packet_end_nx = 1'b1;
          end else begin
            rx_error_nx    = 1'b1;
            rx_err_code_nx = ERR_ALIGN;
          end
        end else if (bit_valid) begin
          shreg_nx   = byte_full;
          bit_cnt_nx = bit_cnt + 3'd1;
          if (last_bit) begin
            if (rx_byte_cnt >= LAST_CNT) begin
              rx_error_nx    = 1'b1;
              rx_err_code_nx = ERR_OVF;
              state_nx       = S_ERR_WAIT;
            end else begin
              rx_data_nx       = byte_full;
              rx_data_valid_nx = 1'b1;
              rx_byte_cnt_nx   = rx_byte_cnt + 1'b1;
            end
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      shreg         <= 8'h00;
      bit_cnt       <= 3'd0;
      rx_active     <= 1'b0;
      pid           <= 4'h0;
      pid_valid     <= 1'b0;
      rx_data       <= 8'h00;
      rx_data_valid <= 1'b0;
      rx_byte_cnt   <= '0;
      rx_packet_end <= 1'b0;
      rx_error      <= 1'b0;
      rx_err_code   <= 3'd0;
    end else begin
      state         <= state_nx;
      shreg         <= shreg_nx;
      bit_cnt       <= bit_cnt_nx;
      rx_active     <= (state_nx == S_PID) || (state_nx == S_DATA);
      pid           <= pid_nx;
      pid_valid     <= pid_valid_nx;
      rx_data       <= rx_data_nx;
      rx_data_valid <= rx_data_valid_nx;
      rx_byte_cnt   <= rx_byte_cnt_nx;
      rx_packet_end <= rx_packet_end_nx;
      rx_error      <= rx_error_nx;
      rx_err_code   <= rx_err_code_nx;
    end
  end

endmodule

// File: doc/usb_rx_packet_ctrl.md
# usb_rx_packet_ctrl

Receive-side packet sequencer for the USB 2.0 full-speed device core. It consumes the unstuffed bit stream together with the SYNC-match pulse and the line-level EOP indication, and frames each packet. It assembles bytes LSB-first, extracts and checks the PID, counts payload bytes, and reports clean end-of-packet or a classified error to the protocol engine. It sits between the SYNC detector / bit-unstuffer and the packet decoder.

## Interface

**Parameters**
- `MAX_BYTES`, default 1026: maximum bytes after SYNC (PID + 1023 data + CRC16). Exceeding it is an overflow error.
- `CNT_W`, default 11: width of the byte counter. Must hold `MAX_BYTES`.

**Ports**
- `clk` input 1: the single clock.
- `rst` input 1: synchronous, active-high reset.
- `bit_valid` input 1: `bit_in` is a valid unstuffed bit this cycle.
- `bit_in` input 1: unstuffed serial data, LSB of each byte first.
- `sync_detected` input 1: one-cycle pulse. The next valid bit is PID bit 0.
- `eop` input 1: one-cycle pulse on detected SE0 end-of-packet.
- `stuff_err` input 1: one-cycle pulse on a bit-stuffing violation.
- `rx_active` output 1: a packet is being framed.
- `pid` output 4: the received PID[3:0]. Held until the next `pid_valid`.
- `pid_valid` output 1: one-cycle pulse when the PID byte is accepted.
- `rx_data` output 8: an assembled post-PID byte.
- `rx_data_valid` output 1: one-cycle pulse per post-PID byte.
- `rx_byte_cnt` output CNT_W: count of post-PID bytes delivered in the current packet.
- `rx_packet_end` output 1: one-cycle pulse on a clean packet end.
- `rx_error` output 1: one-cycle pulse on an aborted packet.
- `rx_err_code` output 3: error class, valid with `rx_error` and held afterward. Values:
  - 1: PID check failed
  - 2: bit-stuff error
  - 3: EOP not byte-aligned, or EOP before the PID completes
  - 4: overflow

## Operation

**States:** IDLE, PID, DATA, ERR_WAIT.

- **IDLE:**
  - On `sync_detected`: go to PID, set `rx_active`=1, clear the bit counter and `rx_byte_cnt`.
  - `eop`, `bit_valid` and `stuff_err` are ignored in IDLE.
- **PID:**
  - Shift `bit_in` into bit 7 of the shift register on each `bit_valid`.
  - When the 8th bit arrives, check the byte:
    - Check passes: `pid`=byte[3:0], pulse `pid_valid`, go to DATA.
    - Check fails: pulse `rx_error` with code 1, go to ERR_WAIT.
- **DATA:**
  - Each complete byte drives `rx_data` and pulses `rx_data_valid`; `rx_byte_cnt` increments in the same cycle.
  - A byte that would make the total bytes after SYNC (including the PID) exceed `MAX_BYTES` is dropped: pulse `rx_error` with code 4, go to ERR_WAIT.
  - `eop` with bit counter = 0: pulse `rx_packet_end`, go to IDLE.
  - `eop` with bit counter ≠ 0: pulse `rx_error` with code 3, go to IDLE.
  - A zero-length packet (EOP straight after the PID) is a clean end with `rx_byte_cnt`=0.
- **`eop` in PID:** pulse `rx_error` with code 3, go to IDLE.
- **`stuff_err` in PID or DATA:** pulse `rx_error` with code 2, go to ERR_WAIT.
- **ERR_WAIT:**
  - Discard bits.
  - On `eop`, go to IDLE; no second pulse is issued.
  - `sync_detected` in ERR_WAIT also returns to IDLE-equivalent handling and starts a new packet (PID state).
- **Packet-level pulses:** exactly one `rx_packet_end` or one `rx_error` per packet, never both.

**Simultaneous events (priority)**
1. `stuff_err`
2. `eop`
3. `bit_valid`

`sync_detected` is ignored in PID and DATA.

## Timing

- **Registered outputs:** all outputs are registered.
  - `pid_valid` / `rx_data_valid` pulse the cycle after the 8th `bit_valid` of a byte.
  - `rx_packet_end` / `rx_error` pulse the cycle after the triggering input.
- **`rx_active`:**
  - Rises the cycle after `sync_detected`.
  - Falls in the same cycle as the `rx_packet_end` or `rx_error` pulse.
  - Stays low in ERR_WAIT.
- **Reset values:**
  - All outputs are 0 on reset, including `pid`, `rx_data`, `rx_byte_cnt` and `rx_err_code`.
  - State returns to IDLE and the shift register and bit counter clear.
  - Reset mid-packet abandons the packet silently, with no `rx_error`.
- **Throughput:** bytes may arrive back-to-back, with `bit_valid` every cycle and no stalls.

## Configuration

- **`USB_RX_PID_CHECK_EN` defined:** the PID byte must satisfy byte[7:4] == ~byte[3:0]. A mismatch gives error code 1.
- **`USB_RX_PID_CHECK_EN` undefined:**
  - No check is performed: every completed PID byte is accepted and `pid_valid` pulses.
  - Code 1 is never produced.

## Test plan

- **Clean DATA0 packet:** SYNC, PID byte 0xC3, data 0x12 0x34, CRC 0xAB 0xCD, then `eop` when aligned.
  - `pid`=0x3 with `pid_valid`.
  - Four `rx_data_valid` pulses carrying 0x12, 0x34, 0xAB, 0xCD.
  - `rx_byte_cnt`=4, then one `rx_packet_end`.
- **Bad PID (with macro):** PID byte 0xC4 → `rx_error`, code 1, no `pid_valid`. Later bits are ignored until `eop`, then SYNC is accepted again.
- **Misaligned EOP:** after PID 0x69 and 1 data byte, 3 more bits then `eop` → `rx_error`, code 3. `rx_byte_cnt`=1.
- **Stuff error:** `stuff_err` and `eop` in the same cycle during DATA → code 2 (not 3), single pulse. Later `eop` returns to IDLE silently.
- **Overflow:** set `MAX_BYTES`=4 and send PID plus 4 data bytes → 3 `rx_data_valid` pulses, then `rx_error` code 4 on the 4th data byte.
- **Reset:** assert `rst` mid-byte in DATA → all outputs 0 next cycle, no pulses. A following SYNC frames normally.
